// File: rtl/perm_inverter.sv
// Serial inverse of a packed permutation word, with a duplicate-value check.
// It takes one word, scans one element per clock for N_ELEM clocks, then holds the result until the consumer takes it.
module perm_inverter #(
   parameter int unsigned ELEM_W = 4,
   parameter int unsigned N_ELEM = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [N_ELEM*ELEM_W-1:0]   in_perm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [N_ELEM*ELEM_W-1:0]   out_inv,
   output logic                       out_ok,
   output logic [ELEM_W-1:0]          out_dup_idx
);

   localparam int unsigned WORD_W = N_ELEM * ELEM_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [WORD_W-1:0]   r_word;
   logic [WORD_W-1:0]   r_inv;
   logic [N_ELEM-1:0]   r_seen;
   logic [ELEM_W-1:0]   r_idx;
   logic [ELEM_W-1:0]   r_dup_idx;
   logic                r_dup;
   logic                r_ok;
   logic                r_in_ready;
   logic                r_out_valid;

   logic                w_accept;
   logic                w_last;
   logic [ELEM_W-1:0]   w_v;
   logic                w_hit;

   // Current element value and whether it has already been seen
   assign w_v      = r_word[r_idx*ELEM_W +: ELEM_W];
   assign w_hit    = r_seen[w_v];
   assign w_last   = (r_idx == ELEM_W'(N_ELEM - 1));
   assign w_accept = (r_state == IDLE) && in_valid;

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = SCAN;
         SCAN:    if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   // State register and handshake flags; the flags are decoded from the next state so they stay registered
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
      end
   end

   // Datapath: latch the word, then scan it one element per clock
   always_ff @(posedge clk) begin
      if (rst) begin
         r_word    <= '0;
         r_inv     <= '0;
         r_seen    <= '0;
         r_idx     <= '0;
         r_dup_idx <= '0;
         r_dup     <= 1'b0;
         r_ok      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_word    <= in_perm;
                  r_inv     <= '0;
                  r_seen    <= '0;
                  r_idx     <= '0;
                  r_dup_idx <= '0;
                  r_dup     <= 1'b0;
                  r_ok      <= 1'b0;
               end
            end
            SCAN: begin
               // Last writer wins when a value repeats
               r_inv[w_v*ELEM_W +: ELEM_W] <= r_idx;
               r_seen[w_v]                 <= 1'b1;
               if (w_hit && !r_dup) begin
                  r_dup     <= 1'b1;
                  r_dup_idx <= r_idx;
               end
               // The final element's duplicate status has to count toward out_ok
               if (w_last) begin
                  r_ok <= ~(r_dup | w_hit);
               end else begin
                  r_idx <= r_idx + ELEM_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_inv     = r_inv;
   assign out_ok      = r_ok;
   assign out_dup_idx = r_dup_idx;

endmodule

// File: tb/tb_perm_inverter.sv
// Self-checking bench for perm_inverter: directed words, backpressure, reset abort and random back-to-back words.
module tb_perm_inverter;

   localparam int unsigned ELEM_W = 4;
   localparam int unsigned N_ELEM = 16;
   localparam int unsigned WORD_W = N_ELEM * ELEM_W;
   localparam logic [WORD_W-1:0] IDENT = 64'hFEDCBA9876543210;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_perm;
   logic              out_valid;
   logic              out_ready;
   logic [WORD_W-1:0] out_inv;
   logic              out_ok;
   logic [ELEM_W-1:0] out_dup_idx;

   int checks   = 0;
   int failures = 0;

   perm_inverter #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_perm     (in_perm),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_inv     (out_inv),
      .out_ok      (out_ok),
      .out_dup_idx (out_dup_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inverse by definition: slot v holds the largest i with p[i]==v, else 0
   function automatic logic [WORD_W-1:0] ref_inv(input logic [WORD_W-1:0] p);
      logic [WORD_W-1:0] r;
      r = '0;
      for (int v = 0; v < int'(N_ELEM); v++)
         for (int i = 0; i < int'(N_ELEM); i++)
            if (p[4*i +: 4] == 4'(v)) r[4*v +: 4] = 4'(i);
      return r;
   endfunction

   // Smallest index whose value matches some earlier element; -1 if none
   function automatic int ref_dup(input logic [WORD_W-1:0] p);
      for (int i = 1; i < int'(N_ELEM); i++)
         for (int j = 0; j < i; j++)
            if (p[4*i +: 4] == p[4*j +: 4]) return i;
      return -1;
   endfunction

   function automatic logic [WORD_W-1:0] rand_perm();
      int a [16];
      int t;
      int j;
      logic [WORD_W-1:0] w;
      for (int i = 0; i < 16; i++) a[i] = i;
      for (int i = 15; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         t = a[i]; a[i] = a[j]; a[j] = t;
      end
      w = '0;
      for (int i = 0; i < 16; i++) w[4*i +: 4] = 4'(a[i]);
      return w;
   endfunction

   task automatic check_result(input string tag, input logic [WORD_W-1:0] p);
      int d;
      d = ref_dup(p);
      chk({tag, "_inv"}, out_inv, ref_inv(p));
      chk({tag, "_ok"}, 64'(out_ok), 64'(d < 0));
      chk({tag, "_dup"}, 64'(out_dup_idx), (d < 0) ? 64'd0 : 64'(d));
   endtask

   // One word through the block; bp>0 holds out_ready low for bp cycles in DONE
   task automatic do_word(input string tag, input logic [WORD_W-1:0] p, input int bp);
      int lat;
      logic [WORD_W-1:0] h_inv;
      logic              h_ok;
      logic [ELEM_W-1:0] h_dup;
      @(negedge clk);
      in_perm   = p;
      in_valid  = 1'b1;
      out_ready = (bp == 0);
      lat = 0;
      while (!in_ready && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd16);
      check_result(tag, p);
      h_inv = out_inv;
      h_ok  = out_ok;
      h_dup = out_dup_idx;
      for (int c = 0; c < bp; c++) begin
         in_valid = 1'b1;
         in_perm  = ~p;
         @(posedge clk);
         #1;
         chk({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
         chk({tag, "_bp_inv"}, out_inv, h_inv);
         chk({tag, "_bp_ok"}, 64'(out_ok), 64'(h_ok));
         chk({tag, "_bp_dup"}, 64'(out_dup_idx), 64'(h_dup));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_post_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   logic [WORD_W-1:0] words [4];
   logic [WORD_W-1:0] sb [$];
   int                acc_cyc [$];
   logic [WORD_W-1:0] exp_p;
   logic [WORD_W-1:0] comp;
   logic [ELEM_W-1:0] v;
   int                n_acc;
   int                n_out;
   bit                pend;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_perm   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_inv", out_inv, 64'd0);
      chk("rst_ok", 64'(out_ok), 64'd0);
      chk("rst_dup", 64'(out_dup_idx), 64'd0);

      do_word("ident", IDENT, 0);
      chk("ident_const", out_inv, IDENT);
      do_word("rot", 64'h0FEDCBA987654321, 0);
      chk("rot_const", out_inv, 64'hEDCBA9876543210F);
      do_word("rev", 64'h0123456789ABCDEF, 0);
      chk("rev_const", out_inv, 64'h0123456789ABCDEF);
      do_word("zero", 64'h0, 0);
      chk("zero_const", out_inv, 64'h000000000000000F);
      do_word("dup3", 64'hFEDCBA9876543310, 5);
      do_word("rand_bp", rand_perm(), 3);

      // Abort a scan with reset at scan cycle 7
      @(negedge clk);
      in_perm  = rand_perm();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_inv", out_inv, 64'd0);
      do_word("after_abort", IDENT, 0);

      // Back-to-back random words with in_valid held high
      for (int i = 0; i < 4; i++) words[i] = rand_perm();
      n_acc = 0;
      n_out = 0;
      pend  = 1'b0;
      @(negedge clk);
      in_perm   = words[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 200 && n_out < 4; c++) begin
         if (in_valid && in_ready) begin
            sb.push_back(in_perm);
            acc_cyc.push_back(c);
            n_acc++;
            pend = 1'b1;
         end
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("b2b_sb_nonempty", 64'd0, 64'd1);
            end else begin
               exp_p = sb.pop_front();
               comp  = '0;
               for (int i = 0; i < int'(N_ELEM); i++) begin
                  v = exp_p[4*i +: 4];
                  comp[4*i +: 4] = out_inv[4*v +: 4];
               end
               chk("b2b_compose", comp, IDENT);
               check_result("b2b", exp_p);
            end
            n_out++;
         end
         @(negedge clk);
         if (pend) begin
            pend = 1'b0;
            if (n_acc < 4) in_perm = words[n_acc];
            else           in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      chk("b2b_outputs", 64'(n_out), 64'd4);
      chk("b2b_accepts", 64'(acc_cyc.size()), 64'd4);
      for (int k = 1; k < acc_cyc.size(); k++)
         chk("b2b_spacing", 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd18);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
